// File: rtl/frodo_mac_if.sv
// Operand/result handshake bundle for the Frodo MAC array.
// The master side feeds beats and accepts results; the slave side is the array.
interface frodo_mac_if #(
  parameter int LANES = 4,
  parameter int W     = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               in_mode;
  logic               in_first;
  logic               in_last;
  logic [LANES*W-1:0] in_a;
  logic [LANES*W-1:0] in_b;
  logic [LANES*W-1:0] in_c;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] out_d;
  logic               err;

  modport master (
    output in_valid, in_mode, in_first, in_last, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_d, err
  );

  modport slave (
    input  in_valid, in_mode, in_first, in_last, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_d, err
  );
endinterface

// File: rtl/frodo_mac_array.sv
// Two-stage multi-lane (a*b + c) mod 2^LOGQ unit with an optional burst
// accumulate mode for dot products; stage 1 multiplies, stage 2 adds/accumulates.
module frodo_mac_array #(
  parameter int LANES = 4,
  parameter int W     = 16,
  parameter int LOGQ  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  frodo_mac_if.slave bus
);
  localparam int DW = LANES * W;
  localparam logic [W-1:0] MASK = {W{1'b1}} >> (W - LOGQ);

  logic          adv;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_mode_q, s1_mode_d;
  logic          s1_first_q, s1_first_d;
  logic          s1_last_q, s1_last_d;
  logic [DW-1:0] s1_p_q, s1_p_d;
  logic [DW-1:0] s1_c_q, s1_c_d;

  logic [DW-1:0] acc_q, acc_d;
  logic          burst_open_q, burst_open_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_d_q, out_d_d;
  logic          err_q, err_d;

  assign adv           = en && (!out_valid_q || bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_d     = out_d_q;
  assign bus.err       = err_q;

  // A W-bit product keeps exactly the low W bits of the full 2W product,
  // so masking it afterwards gives the truncated product mod 2^LOGQ.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_p_d     = s1_p_q;
    s1_c_d     = s1_c_q;
    if (adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mode_d  = bus.in_mode;
        s1_first_d = bus.in_first;
        s1_last_d  = bus.in_last;
        s1_c_d     = bus.in_c;
        for (int i = 0; i < LANES; i++) begin
          s1_p_d[i*W +: W] = (bus.in_a[i*W +: W] * bus.in_b[i*W +: W]) & MASK;
        end
      end
    end
  end

  always_comb begin
    acc_d        = acc_q;
    burst_open_d = burst_open_q;
    out_valid_d  = out_valid_q;
    out_d_d      = out_d_q;
    err_d        = err_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        if (!s1_mode_q) begin
          for (int i = 0; i < LANES; i++) begin
            out_d_d[i*W +: W] = (s1_p_q[i*W +: W] + s1_c_q[i*W +: W]) & MASK;
          end
          out_valid_d = 1'b1;
        end else begin
          // Both protocol errors collapse to first == burst_open.
          if (s1_first_q == burst_open_q) begin
            err_d = 1'b1;
          end
          for (int i = 0; i < LANES; i++) begin
            acc_d[i*W +: W] = ((s1_first_q ? s1_c_q[i*W +: W] : acc_q[i*W +: W])
                               + s1_p_q[i*W +: W]) & MASK;
          end
          if (s1_first_q) begin
            burst_open_d = 1'b1;
          end
          if (s1_last_q) begin
            burst_open_d = 1'b0;
            out_d_d      = acc_d;
            out_valid_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_p_q       <= '0;
      s1_c_q       <= '0;
      acc_q        <= '0;
      burst_open_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_d_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_first_q   <= s1_first_d;
      s1_last_q    <= s1_last_d;
      s1_p_q       <= s1_p_d;
      s1_c_q       <= s1_c_d;
      acc_q        <= acc_d;
      burst_open_q <= burst_open_d;
      out_valid_q  <= out_valid_d;
      out_d_q      <= out_d_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_frodo_mac_array.sv
// Directed bench for frodo_mac_array: one instance at LOGQ=16 and a twin at
// LOGQ=15 fed the same beats, so modulus wrap can be compared side by side.
module tb_frodo_mac_array;
  localparam int LANES = 4;
  localparam int W     = 16;
  localparam int DW    = LANES * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          in_valid, in_mode, in_first, in_last, out_ready;
  logic [DW-1:0] in_a, in_b, in_c;

  int total = 0;
  int bad   = 0;

  frodo_mac_if #(.LANES(LANES), .W(W)) if16 ();
  frodo_mac_if #(.LANES(LANES), .W(W)) if15 ();

  assign if16.in_valid  = in_valid;
  assign if16.in_mode   = in_mode;
  assign if16.in_first  = in_first;
  assign if16.in_last   = in_last;
  assign if16.in_a      = in_a;
  assign if16.in_b      = in_b;
  assign if16.in_c      = in_c;
  assign if16.out_ready = out_ready;
  assign if15.in_valid  = in_valid;
  assign if15.in_mode   = in_mode;
  assign if15.in_first  = in_first;
  assign if15.in_last   = in_last;
  assign if15.in_a      = in_a;
  assign if15.in_b      = in_b;
  assign if15.in_c      = in_c;
  assign if15.out_ready = out_ready;

  frodo_mac_array #(.LANES(LANES), .W(W), .LOGQ(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .bus(if16)
  );
  frodo_mac_array #(.LANES(LANES), .W(W), .LOGQ(15)) dut15 (
    .clk(clk), .reset(reset), .en(en), .bus(if15)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] exp16;
    logic [DW-1:0] exp15;
  } vec_t;

  vec_t          vecs[4];
  logic [DW-1:0] bp_exp[4];

  task automatic applyStimulus(input logic mode, input logic first, input logic last,
                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] c);
    in_valid = 1'b1;
    in_mode  = mode;
    in_first = first;
    in_last  = last;
    in_a     = a;
    in_b     = b;
    in_c     = c;
  endtask

  task automatic idleInput();
    in_valid = 1'b0;
    in_mode  = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_c     = '0;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  sent;
    int  recv;
    int  stalls;
    logic fire;

    vecs[0] = '{a: {16'hFFFF, 16'h0000, 16'h0008, 16'h000F},
                b: {16'h0001, 16'h0000, 16'h0007, 16'h0003},
                c: {16'd1000, 16'h0000, 16'd12,   16'd5},
                exp16: {16'h03E7, 16'h0000, 16'h0044, 16'h0032},
                exp15: {16'h03E7, 16'h0000, 16'h0044, 16'h0032}};
    vecs[1] = '{a: {4{16'h4000}}, b: {4{16'h0002}}, c: {4{16'h0001}},
                exp16: {4{16'h8001}}, exp15: {4{16'h0001}}};
    vecs[2] = '{a: {16'h0003, 16'h0100, 16'hFFFF, 16'h1234},
                b: {16'h0005, 16'h0100, 16'hFFFF, 16'h0010},
                c: {16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001},
                exp16: {16'h800E, 16'hFFFF, 16'h0001, 16'h2341},
                exp15: {16'h000E, 16'h7FFF, 16'h0001, 16'h2341}};
    vecs[3] = '{a: {16'h7FFF, 16'hAAAA, 16'h0002, 16'h8000},
                b: {16'h7FFF, 16'h0002, 16'h0003, 16'h0001},
                c: {16'h0000, 16'h0000, 16'h0004, 16'h8000},
                exp16: {16'h0001, 16'h5554, 16'h000A, 16'h0000},
                exp15: {16'h0001, 16'h5554, 16'h000A, 16'h0000}};
    for (int k = 0; k < 4; k++) begin
      bp_exp[k] = {4{16'(11 * k + 10)}};
    end

    reset     = 1'b1;
    en        = 1'b1;
    out_ready = 1'b1;
    idleInput();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(if16.out_valid), 64'd0);
    checkOutput("reset out_d", if16.out_d, 64'd0);
    checkOutput("reset err", 64'(if16.err), 64'd0);
    checkOutput("reset in_ready", 64'(if16.in_ready), 64'd1);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, vecs[i].a, vecs[i].b, vecs[i].c);
      @(negedge clk);
      idleInput();
      checkOutput($sformatf("vec%0d early out_valid", i), 64'(if16.out_valid), 64'd0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d out_valid", i), 64'(if16.out_valid), 64'd1);
      checkOutput($sformatf("vec%0d out_d logq16", i), if16.out_d, vecs[i].exp16);
      checkOutput($sformatf("vec%0d out_d logq15", i), if15.out_d, vecs[i].exp15);
    end

    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'd1, 64'd2, 64'd10);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd3, 64'd4, 64'd0);
    checkOutput("burst beat0 no out", 64'(if16.out_valid), 64'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'd5, 64'd6, 64'd0);
    checkOutput("burst beat1 no out", 64'(if16.out_valid), 64'd0);
    @(negedge clk);
    idleInput();
    checkOutput("burst beat2 early", 64'(if16.out_valid), 64'd0);
    @(negedge clk);
    checkOutput("burst out_valid", 64'(if16.out_valid), 64'd1);
    checkOutput("burst sum", if16.out_d, 64'h36);
    checkOutput("burst err", 64'(if16.err), 64'd0);

    sent   = 0;
    recv   = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (sent < 4) begin
        applyStimulus(1'b0, 1'b0, 1'b0, {4{16'(sent + 1)}}, {4{16'd10}}, {4{16'(sent)}});
      end else begin
        idleInput();
      end
      #1;
      if (if16.out_valid && !out_ready) begin
        stalls++;
        checkOutput("bp stall out_d", if16.out_d, bp_exp[recv]);
        checkOutput("bp stall in_ready", 64'(if16.in_ready), 64'd0);
      end
      if (if16.out_valid && out_ready) begin
        checkOutput($sformatf("bp result%0d", recv), if16.out_d, bp_exp[recv]);
        recv++;
      end
      fire = in_valid && if16.in_ready;
      @(posedge clk);
      if (fire) sent++;
    end
    out_ready = 1'b1;
    checkOutput("bp results received", 64'(recv), 64'd4);
    checkOutput("bp stall cycles", 64'(stalls), 64'd3);
    @(negedge clk);
    idleInput();
    checkOutput("bp no duplicate", 64'(if16.out_valid), 64'd0);

    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, {4{16'd100}}, {4{16'd3}}, {4{16'd7}});
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, {4{16'h0102}}, {4{16'h0100}}, {4{16'd5}});
    @(negedge clk);
    idleInput();
    en = 1'b0;
    #1;
    checkOutput("en0 out_d A", if16.out_d, {4{16'h0133}});
    checkOutput("en0 in_ready", 64'(if16.in_ready), 64'd0);
    @(negedge clk);
    checkOutput("en0 frozen valid", 64'(if16.out_valid), 64'd1);
    checkOutput("en0 frozen out_d", if16.out_d, {4{16'h0133}});
    @(negedge clk);
    checkOutput("en0 still frozen", if16.out_d, {4{16'h0133}});
    en = 1'b1;
    @(negedge clk);
    checkOutput("en resume valid", 64'(if16.out_valid), 64'd1);
    checkOutput("en resume out_d B", if16.out_d, {4{16'h0205}});
    @(negedge clk);
    checkOutput("en resume drained", 64'(if16.out_valid), 64'd0);

    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'd1, 64'd1, 64'd0);
    @(negedge clk);
    idleInput();
    @(negedge clk);
    checkOutput("stale acc out_d", if16.out_d, 64'h37);
    checkOutput("stale acc err", 64'(if16.err), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("err sticky", 64'(if16.err), 64'd1);

    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'd7, 64'd7, 64'd3);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd2, 64'd2, 64'd0);
    @(negedge clk);
    idleInput();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid-burst reset err", 64'(if16.err), 64'd0);
    checkOutput("mid-burst reset out_valid", 64'(if16.out_valid), 64'd0);
    checkOutput("mid-burst reset out_d", if16.out_d, 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset discards in-flight", 64'(if16.out_valid), 64'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'd2, 64'd3, 64'd1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'd4, 64'd5, 64'd0);
    @(negedge clk);
    idleInput();
    @(negedge clk);
    checkOutput("fresh burst valid", 64'(if16.out_valid), 64'd1);
    checkOutput("fresh burst sum", if16.out_d, 64'h1B);
    checkOutput("fresh burst err", 64'(if16.err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frodo_mac_array.md
Name: frodo_mac_array

Overview:
- Parametrised, pipelined multi-lane multiply-accumulate unit for Frodo matrix arithmetic; computes out = (a*b + c) mod 2^LOGQ per lane.
- Successor to the single-lane 16-bit a*b+c adder: adds lanes, a configurable modulus, valid/ready handshaking with backpressure, and a burst dot-product accumulate mode.
- Sits between the matrix operand fetch logic and the result write-back buffer.

Parameters:
- LANES, 4, number of independent lanes
- W, 16, operand/result width per lane
- LOGQ, 16, modulus exponent; results are reduced mod 2^LOGQ; legal range 1 <= LOGQ <= W

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  global enable; 0 freezes all state
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_mode  in  1  0 = elementwise a*b+c; 1 = accumulate burst
- in_first  in  1  mode 1 only: first beat of burst; loads c
- in_last  in  1  mode 1 only: last beat of burst; emits result
- in_a  in  LANES*W  lane i at [i*W +: W]
- in_b  in  LANES*W  per-lane multiplier
- in_c  in  LANES*W  per-lane addend (mode 1: sampled on first beat only)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_d  out  LANES*W  per-lane result; bits above LOGQ are zero
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (synchronous, wins over everything): out_valid=0, out_d=0, err=0, accumulator=0, burst_open=0, stage-1 valid=0.
- adv = en && (!out_valid || out_ready). in_ready = adv. The pipeline advances only when adv=1. When en=0, nothing changes and out_d/out_valid hold.
- Stage 1 (on accepted beat): register p_i = (a_i*b_i) mod 2^LOGQ for each lane (full 2W product, truncated), plus c_i, mode, first, last and s1_valid. If adv=1 and no beat is accepted, s1_valid becomes 0.
- Stage 2 (when adv && s1_valid):
  - Mode 0: out_d_i = (p_i + c_i) mod 2^LOGQ; out_valid=1. Accumulator and burst_open are untouched, so mode-0 beats may interleave with an open burst.
  - Mode 1 with first=1: acc_i = (c_i + p_i) mod 2^LOGQ; burst_open=1.
  - Mode 1 with first=0: acc_i = (acc_i + p_i) mod 2^LOGQ.
  - Mode 1 with last=1: out_d_i = the new acc_i; out_valid=1; burst_open=0. first=last=1 is a one-beat burst.
  - Mode 1 with last=0: no output. out_valid drops to 0 if it was just consumed.
- out_valid clears on out_ready when stage 2 produces no new result the same cycle. Back-to-back results at 1 per cycle are supported when out_ready=1.
- Latency: 2 cycles from acceptance to out_valid (mode 0), or from acceptance of the last beat (mode 1), with no backpressure.
- Backpressure: while out_valid && !out_ready, out_d is stable, in_ready=0, and stage 1 holds.
- err (sticky until reset), evaluated at stage 2:
  - mode 1, first=0 while burst_open=0: the beat is accumulated onto the stale acc anyway.
  - mode 1, first=1 while burst_open=1: the old burst is discarded and restarted.
- All additions are modular and wrap silently; no saturation.
- Reset mid-burst or mid-stall discards all in-flight data; no output is produced for it.

Test Plan:
- Elementwise, LOGQ=16: lane0 a=15,b=3,c=5; lane1 a=8,b=7,c=12; lane2 0,0,0; lane3 a=0xFFFF,b=1,c=1000 -> 2 cycles later out_valid=1, out_d lanes = 0x0032, 0x0044, 0x0000, 0x03E7.
- Modulus wrap: a=0x4000, b=2, c=1 -> LOGQ=16 gives 0x8001; LOGQ=15 gives 0x0001, and bit 15 of every lane is 0.
- Accumulate burst, lane0 beats (1,2,c=10,first), (3,4), (5,6,last) -> single output 0x0036 two cycles after the last beat; no out_valid on earlier beats.
- Backpressure: stream 4 mode-0 beats with out_ready low for 3 cycles -> out_d stable, in_ready=0; after release all 4 results arrive in order, none lost or duplicated.
- en=0 for 2 cycles mid-pipeline -> all outputs frozen; results resume unchanged with latency extended by 2.
- Protocol/reset: mode-1 beat with first=0 and no open burst -> err=1 and stays 1. Then assert reset mid-burst -> err=0, out_valid=0, and a following fresh burst yields the correct sum.
